// File: rtl/mem_access_pkg.sv
// Shared types and helpers for the memory-access pipeline stage.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package mem_access_pkg;

  // Decoded operation handed over from execute.
  typedef enum logic [4:0] {
    NOP,
    ADD,
    ADDI,
    SUB,
    LB,
    LH,
    LW,
    LD,
    LBU,
    LHU,
    LWU,
    SB,
    SH,
    SW,
    SD
  } instruction_type;

  // Encoding matches the dreq_size bus field (0=byte .. 3=dword).
  typedef enum logic [2:0] {
    MSIZE1 = 3'd0,
    MSIZE2 = 3'd1,
    MSIZE4 = 3'd2,
    MSIZE8 = 3'd3
  } mem_size_t;

  typedef enum logic [1:0] {
    IDLE,
    BUS,
    DONE
  } mem_state_t;

  function automatic logic is_load(input instruction_type op);
    return (op == LB) || (op == LH) || (op == LW) || (op == LD) ||
           (op == LBU) || (op == LHU) || (op == LWU);
  endfunction

  function automatic logic is_store(input instruction_type op);
    return (op == SB) || (op == SH) || (op == SW) || (op == SD);
  endfunction

  function automatic mem_size_t op_size(input instruction_type op);
    case (op)
      LB, LBU, SB: return MSIZE1;
      LH, LHU, SH: return MSIZE2;
      LW, LWU, SW: return MSIZE4;
      default:     return MSIZE8;
    endcase
  endfunction

  // True when the byte offset is not a multiple of the access size.
  function automatic logic is_misaligned(input mem_size_t sz, input logic [2:0] off);
    case (sz)
      MSIZE1:  return 1'b0;
      MSIZE2:  return off[0];
      MSIZE4:  return |off[1:0];
      default: return |off;
    endcase
  endfunction

endpackage

// File: rtl/mem_align.sv
// Byte-lane alignment: store lane shift + strobe, load shift + sign/zero extension.
// Latency: combinational.
// Backpressure: none (pure function of its inputs).
// Ports: op/off select size and lane; store_data -> lane_data/strobe;
//        load_data -> load_result. Strobe shift is truncated to 8 bits.
module mem_align
  import mem_access_pkg::*;
(
  input  instruction_type op,
  input  logic [2:0]      off,
  input  logic [63:0]     store_data,
  input  logic [63:0]     load_data,
  output logic [63:0]     lane_data,
  output logic [7:0]      strobe,
  output logic [63:0]     load_result
);

  logic [5:0]  bit_sh;
  logic [63:0] shifted;

  assign bit_sh    = {off, 3'b000};
  assign lane_data = store_data << bit_sh;
  assign shifted   = load_data >> bit_sh;

  always_comb begin
    strobe = 8'h00;
    case (op_size(op))
      MSIZE1:  strobe = 8'h01 << off;
      MSIZE2:  strobe = 8'h03 << off;
      MSIZE4:  strobe = 8'h0F << off;
      default: strobe = 8'hFF;
    endcase
  end

  always_comb begin
    load_result = shifted;
    case (op)
      LB:      load_result = {{56{shifted[7]}},  shifted[7:0]};
      LH:      load_result = {{48{shifted[15]}}, shifted[15:0]};
      LW:      load_result = {{32{shifted[31]}}, shifted[31:0]};
      LBU:     load_result = {56'd0, shifted[7:0]};
      LHU:     load_result = {48'd0, shifted[15:0]};
      LWU:     load_result = {32'd0, shifted[31:0]};
      default: load_result = shifted;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// Memory stage of the RV64 pipeline: issues data-bus requests and aligns load data.
// Latency: 1 cycle for non-memory ops; accept + bus wait + 1 for memory ops (min 2).
// Backpressure: in_ready=1 in IDLE, =out_ready in DONE, 0 while waiting on the bus.
// Ports: in_* from execute, dreq_*/dresp_* data bus, out_* to writeback.
// Optional: MEM_MISALIGN_CHECK_EN adds out_misalign and traps misaligned ops
//           without touching the bus.
module mem_access
  import mem_access_pkg::*;
#(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  instruction_type       in_op,
  input  logic [63:0]           in_result,
  input  logic [63:0]           in_store_data,
  input  logic [4:0]            in_rd,
  output logic                  dreq_valid,
  output logic [ADDR_WIDTH-1:0] dreq_addr,
  output logic [2:0]            dreq_size,
  output logic [7:0]            dreq_strobe,
  output logic [63:0]           dreq_data,
  input  logic                  dresp_data_ok,
  input  logic [63:0]           dresp_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [63:0]           out_result,
  output logic [4:0]            out_rd,
  output logic                  out_wen
`ifdef MEM_MISALIGN_CHECK_EN
  ,
  output logic                  out_misalign
`endif
);

  if (DATA_WIDTH != 64) begin : g_dw_check
    $error("mem_access: only DATA_WIDTH = 64 is supported");
  end

  mem_state_t      state;
  instruction_type op_q;
  logic [4:0]      rd_q;

  logic            accept;
  logic            in_is_mem;
  logic            take_fault;

  instruction_type al_op;
  logic [2:0]      al_off;
  logic [63:0]     al_lane;
  logic [7:0]      al_strobe;
  logic [63:0]     al_load;

  assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign in_is_mem = is_load(in_op) || is_store(in_op);

`ifdef MEM_MISALIGN_CHECK_EN
  assign take_fault = in_is_mem && is_misaligned(op_size(in_op), in_result[2:0]);
`else
  assign take_fault = 1'b0;
`endif

  // One aligner serves both directions: while waiting on the bus it sees the
  // latched op/offset (load extension); otherwise it sees the incoming op
  // (store lane shift at acceptance).
  assign al_op  = (state == BUS) ? op_q : in_op;
  assign al_off = (state == BUS) ? dreq_addr[2:0] : in_result[2:0];

  mem_align u_align (
    .op          (al_op),
    .off         (al_off),
    .store_data  (in_store_data),
    .load_data   (dresp_data),
    .lane_data   (al_lane),
    .strobe      (al_strobe),
    .load_result (al_load)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      op_q         <= NOP;
      rd_q         <= '0;
      dreq_valid   <= 1'b0;
      dreq_addr    <= '0;
      dreq_size    <= '0;
      dreq_strobe  <= '0;
      dreq_data    <= '0;
      out_valid    <= 1'b0;
      out_result   <= '0;
      out_rd       <= '0;
      out_wen      <= 1'b0;
`ifdef MEM_MISALIGN_CHECK_EN
      out_misalign <= 1'b0;
`endif
    end else begin
      case (state)
        BUS: begin
          if (dresp_data_ok) begin
            dreq_valid  <= 1'b0;
            dreq_strobe <= '0;
            out_valid   <= 1'b1;
            out_result  <= is_load(op_q) ? al_load : '0;
            out_rd      <= rd_q;
            out_wen     <= is_load(op_q) && (rd_q != 5'd0);
            state       <= DONE;
          end
        end
        default: begin  // IDLE or DONE
          if ((state == DONE) && out_ready) begin
            out_valid    <= 1'b0;
            out_wen      <= 1'b0;
`ifdef MEM_MISALIGN_CHECK_EN
            out_misalign <= 1'b0;
`endif
            state        <= IDLE;
          end
          if (accept) begin
            if (take_fault) begin
              // Faulting address is reported in place of a result.
              out_valid    <= 1'b1;
              out_result   <= in_result;
              out_rd       <= in_rd;
              out_wen      <= 1'b0;
`ifdef MEM_MISALIGN_CHECK_EN
              out_misalign <= 1'b1;
`endif
              state        <= DONE;
            end else if (in_is_mem) begin
              op_q        <= in_op;
              rd_q        <= in_rd;
              dreq_valid  <= 1'b1;
              dreq_addr   <= in_result[ADDR_WIDTH-1:0];
              dreq_size   <= op_size(in_op);
              dreq_strobe <= is_store(in_op) ? al_strobe : 8'h00;
              dreq_data   <= is_store(in_op) ? al_lane : '0;
              out_valid   <= 1'b0;
              out_wen     <= 1'b0;
              state       <= BUS;
            end else begin
              out_valid    <= 1'b1;
              out_result   <= in_result;
              out_rd       <= in_rd;
              out_wen      <= (in_rd != 5'd0);
`ifdef MEM_MISALIGN_CHECK_EN
              out_misalign <= 1'b0;
`endif
              state        <= DONE;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: stores, loads, pass-through, stall and reset abort.
// Latency: n/a.
// Backpressure: exercised via out_ready stalls.
module tb_mem_access;
  import mem_access_pkg::*;

  logic            clk = 1'b0;
  logic            reset;
  logic            in_valid;
  logic            in_ready;
  instruction_type in_op;
  logic [63:0]     in_result;
  logic [63:0]     in_store_data;
  logic [4:0]      in_rd;
  logic            dreq_valid;
  logic [63:0]     dreq_addr;
  logic [2:0]      dreq_size;
  logic [7:0]      dreq_strobe;
  logic [63:0]     dreq_data;
  logic            dresp_data_ok;
  logic [63:0]     dresp_data;
  logic            out_valid;
  logic            out_ready;
  logic [63:0]     out_result;
  logic [4:0]      out_rd;
  logic            out_wen;
`ifdef MEM_MISALIGN_CHECK_EN
  logic            out_misalign;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_access #(.ADDR_WIDTH(64), .DATA_WIDTH(64)) dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_op         (in_op),
    .in_result     (in_result),
    .in_store_data (in_store_data),
    .in_rd         (in_rd),
    .dreq_valid    (dreq_valid),
    .dreq_addr     (dreq_addr),
    .dreq_size     (dreq_size),
    .dreq_strobe   (dreq_strobe),
    .dreq_data     (dreq_data),
    .dresp_data_ok (dresp_data_ok),
    .dresp_data    (dresp_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_result    (out_result),
    .out_rd        (out_rd),
    .out_wen       (out_wen)
`ifdef MEM_MISALIGN_CHECK_EN
    ,
    .out_misalign  (out_misalign)
`endif
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input instruction_type op, input logic [63:0] res,
                       input logic [63:0] sd, input logic [4:0] rd);
    in_valid      = 1'b1;
    in_op         = op;
    in_result     = res;
    in_store_data = sd;
    in_rd         = rd;
  endtask

  task automatic idle_in();
    in_valid      = 1'b0;
    in_op         = NOP;
    in_result     = '0;
    in_store_data = '0;
    in_rd         = '0;
  endtask

  // Issue a load and answer it in the first cycle dreq_valid is high.
  task automatic do_load(input instruction_type op, input logic [63:0] addr,
                         input logic [63:0] data, input logic [4:0] rd);
    drive(op, addr, 64'd0, rd);
    step();
    idle_in();
    check_eq("ld_req_vld", dreq_valid, 1);
    check_eq("ld_strobe", dreq_strobe, 0);
    dresp_data    = data;
    dresp_data_ok = 1'b1;
    step();
    dresp_data_ok = 1'b0;
    dresp_data    = '0;
    check_eq("ld_out_vld", out_valid, 1);
  endtask

  initial begin
    reset         = 1'b0;
    idle_in();
    dresp_data_ok = 1'b0;
    dresp_data    = '0;
    out_ready     = 1'b1;

    #12;
    check_eq("rst_dreq_vld", dreq_valid, 0);
    check_eq("rst_strobe", dreq_strobe, 0);
    check_eq("rst_out_vld", out_valid, 0);
    check_eq("rst_out_wen", out_wen, 0);
    check_eq("rst_out_res", out_result, 0);
    check_eq("rst_addr", dreq_addr, 0);
    @(negedge clk);
    reset = 1'b1;
    step();
    check_eq("idle_in_rdy", in_ready, 1);

    // SW 0x1004: word in the upper half, bus answers on the third cycle.
    drive(SW, 64'h1004, 64'hDEADBEEF_12345678, 5'd9);
    step();
    idle_in();
    for (int i = 0; i < 3; i++) begin
      check_eq("sw_vld", dreq_valid, 1);
      check_eq("sw_addr", dreq_addr, 64'h1004);
      check_eq("sw_size", dreq_size, 2);
      check_eq("sw_strobe", dreq_strobe, 8'hF0);
      check_eq("sw_data", dreq_data, 64'h12345678_00000000);
      check_eq("sw_in_rdy", in_ready, 0);
      if (i == 2) dresp_data_ok = 1'b1;
      step();
    end
    dresp_data_ok = 1'b0;
    check_eq("sw_out_vld", out_valid, 1);
    check_eq("sw_req_drop", dreq_valid, 0);
    check_eq("sw_wen", out_wen, 0);
    step();
    check_eq("sw_retire", out_valid, 0);

    // Loads against lane data 0x8000_0000.
    do_load(LB, 64'h2003, 64'h0000_0000_8000_0000, 5'd3);
    check_eq("lb_res", out_result, 64'hFFFF_FFFF_FFFF_FF80);
    check_eq("lb_wen", out_wen, 1);
    check_eq("lb_rd", out_rd, 3);
    step();
    do_load(LBU, 64'h2003, 64'h0000_0000_8000_0000, 5'd3);
    check_eq("lbu_res", out_result, 64'h80);
    step();
    do_load(LWU, 64'h2000, 64'h0000_0000_8000_0000, 5'd3);
    check_eq("lwu_res", out_result, 64'h8000_0000);
    step();
    do_load(LW, 64'h2000, 64'h0000_0000_8000_0000, 5'd3);
    check_eq("lw_res", out_result, 64'hFFFF_FFFF_8000_0000);
    step();
    do_load(LH, 64'h2002, 64'h0000_0000_8000_0000, 5'd3);
    check_eq("lh_res", out_result, 64'hFFFF_FFFF_FFFF_8000);
    step();
    do_load(LD, 64'h2000, 64'hCAFE_0000_1234_5678, 5'd0);
    check_eq("ld_x0_res", out_result, 64'hCAFE_0000_1234_5678);
    check_eq("ld_x0_wen", out_wen, 0);
    step();

    // Back-to-back pass-through ops.
    drive(ADD, 64'd42, 64'd0, 5'd1);
    step();
    check_eq("add_vld", out_valid, 1);
    check_eq("add_res", out_result, 42);
    check_eq("add_wen", out_wen, 1);
    check_eq("add_in_rdy", in_ready, 1);
    check_eq("add_no_req", dreq_valid, 0);
    drive(ADDI, 64'd7, 64'd0, 5'd2);
    step();
    check_eq("addi_vld", out_valid, 1);
    check_eq("addi_res", out_result, 7);
    check_eq("addi_rd", out_rd, 2);
    check_eq("addi_no_req", dreq_valid, 0);
    drive(ADD, 64'd99, 64'd0, 5'd0);
    step();
    check_eq("x0_res", out_result, 99);
    check_eq("x0_wen", out_wen, 0);
    idle_in();
    step();
    check_eq("b2b_drain", out_valid, 0);
    check_eq("b2b_no_req", dreq_valid, 0);

    // LD with writeback stalled for 4 cycles; a SUB waits at the input.
    out_ready = 1'b0;
    drive(LD, 64'h3000, 64'd0, 5'd7);
    step();
    idle_in();
    dresp_data    = 64'h0123_4567_89AB_CDEF;
    dresp_data_ok = 1'b1;
    step();
    dresp_data_ok = 1'b0;
    dresp_data    = '0;
    drive(SUB, 64'd5, 64'd0, 5'd4);
    for (int i = 0; i < 4; i++) begin
      check_eq("stall_vld", out_valid, 1);
      check_eq("stall_res", out_result, 64'h0123_4567_89AB_CDEF);
      check_eq("stall_rd", out_rd, 7);
      check_eq("stall_in_rdy", in_ready, 0);
      step();
    end
    out_ready = 1'b1;
    #1;
    check_eq("stall_release_rdy", in_ready, 1);
    step();
    check_eq("sub_vld", out_valid, 1);
    check_eq("sub_res", out_result, 5);
    check_eq("sub_rd", out_rd, 4);
    idle_in();
    step();
    check_eq("sub_drain", out_valid, 0);

`ifdef MEM_MISALIGN_CHECK_EN
    drive(LH, 64'h1001, 64'd0, 5'd6);
    step();
    idle_in();
    check_eq("mis_flag", out_misalign, 1);
    check_eq("mis_vld", out_valid, 1);
    check_eq("mis_res", out_result, 64'h1001);
    check_eq("mis_wen", out_wen, 0);
    check_eq("mis_no_req", dreq_valid, 0);
    step();
    check_eq("mis_drain", out_valid, 0);
    check_eq("mis_no_req2", dreq_valid, 0);
`else
    // Misaligned SH at offset 7 goes to the bus with a truncated strobe.
    drive(SH, 64'h1007, 64'h0000_0000_0000_ABCD, 5'd6);
    step();
    idle_in();
    check_eq("sh7_vld", dreq_valid, 1);
    check_eq("sh7_size", dreq_size, 1);
    check_eq("sh7_strobe", dreq_strobe, 8'h80);
    check_eq("sh7_data", dreq_data, 64'hCD00_0000_0000_0000);
    dresp_data_ok = 1'b1;
    step();
    dresp_data_ok = 1'b0;
    check_eq("sh7_out_vld", out_valid, 1);
    step();
`endif

    // Reset during BUS aborts the request; a late response is ignored.
    drive(LD, 64'h4000, 64'd0, 5'd3);
    step();
    idle_in();
    check_eq("abort_pre_vld", dreq_valid, 1);
    #2;
    reset = 1'b0;
    #1;
    check_eq("abort_req_drop", dreq_valid, 0);
    check_eq("abort_out_vld", out_valid, 0);
    @(negedge clk);
    reset = 1'b1;
    step();
    dresp_data    = 64'hFFFF;
    dresp_data_ok = 1'b1;
    step();
    dresp_data_ok = 1'b0;
    dresp_data    = '0;
    check_eq("stale_out_vld", out_valid, 0);
    check_eq("stale_req_vld", dreq_valid, 0);
    check_eq("stale_in_rdy", in_ready, 1);
    step();
    check_eq("stale_out_vld2", out_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
- Memory stage of the 5-stage RV64 pipeline; sits between execute and writeback.
- Consumes the execute result: the effective address for LD/LB/LH/LW/LBU/LHU/LWU/SD/SB/SH/SW, or the final value for arithmetic ops.
- Drives the data-bus request, waits for the response, and aligns plus sign/zero-extends load data.
- Non-memory ops pass through with one register stage.

Parameters:
- ADDR_WIDTH, 64, data-bus address width.
- DATA_WIDTH, 64, data-bus data width; only 64 is supported, and an elaboration-time assertion enforces this.

Ports:
- clk  in  1  pipeline clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  execute stage presents an instruction.
- in_ready  out  1  stage can accept this cycle.
- in_op  in  instruction_type  decoded op.
- in_result  in  64  execute-stage result; the effective address for memory ops.
- in_store_data  in  64  rs2 value, used for stores.
- in_rd  in  5  destination register.
- dreq_valid  out  1  bus request valid.
- dreq_addr  out  ADDR_WIDTH  request address; the full byte address is passed through.
- dreq_size  out  3  0=byte, 1=half, 2=word, 3=dword.
- dreq_strobe  out  8  byte write enables; 0 for loads.
- dreq_data  out  64  store data, lane-shifted.
- dresp_data_ok  in  1  one-cycle pulse: request completed.
- dresp_data  in  64  raw 64-bit lane read data.
- out_valid  out  1  writeback entry valid.
- out_ready  in  1  writeback accepts.
- out_result  out  64  final value; load data after extension.
- out_rd  out  5  destination register.
- out_wen  out  1  register write enable; 0 for stores and when rd = x0.

Behaviour:
- Reset (asynchronous, while reset = 0):
  - State goes to IDLE.
  - dreq_valid = 0, dreq_strobe = 0, out_valid = 0, out_wen = 0.
  - All data registers are cleared to 0.
  - A reset during BUS aborts the request. A dresp_data_ok arriving after reset deasserts is ignored.
- State IDLE:
  - in_ready = 1.
  - On in_valid with a memory op: latch op, address, rd and lane-shifted store data; go to BUS; assert dreq_valid on the next cycle.
  - On in_valid with a non-memory op: go to DONE with out_result = in_result.
- State BUS:
  - dreq_valid = 1. addr/size/strobe/data are held stable until dresp_data_ok.
  - in_ready = 0.
  - On dresp_data_ok: capture and extend the data, deassert dreq_valid in the same edge, go to DONE.
  - dresp_data_ok arriving in the same cycle dreq_valid first rises is legal: latency is 2 cycles from acceptance to out_valid.
- State DONE:
  - out_valid = 1. Outputs are held until out_ready.
  - On out_valid & out_ready with in_valid: accept the next instruction in the same cycle (in_ready = out_ready in DONE), giving back-to-back throughput of 1/cycle for non-memory ops.
  - Otherwise return to IDLE.
- Sizes:
  - LB/LBU/SB = 0; LH/LHU/SH = 1; LW/LWU/SW = 2; LD/SD = 3.
- Store lane and strobe:
  - Lane offset: off = addr[2:0].
  - dreq_data = store_data << (8*off).
  - dreq_strobe: SB = 8'h01<<off, SH = 8'h03<<off, SW = 8'h0F<<off, SD = 8'hFF.
- Load alignment:
  - Load data: shifted = dresp_data >> (8*off).
  - LB/LH/LW sign-extend from bit 7/15/31.
  - LBU/LHU/LWU zero-extend. LD uses the data unmodified.
- Writeback enable:
  - out_wen = 0 for stores and for rd = 0; otherwise 1.
- Misalignment (feature disabled):
  - Misaligned accesses are issued as-is. Behaviour is bus-defined.
  - The strobe shift is truncated to 8 bits.

Optional Feature:
- MEM_MISALIGN_CHECK_EN
  - Defined:
    - Adds output port out_misalign (1 bit).
    - Misalignment is off not a multiple of the access size.
    - A misaligned memory op skips BUS and goes directly to DONE.
    - In DONE: out_misalign = 1, out_wen = 0, out_result = faulting address, no bus request issued.
    - out_misalign resets to 0.
  - Undefined: the port is absent and no check is made.

Decomposition:
- In common package:
  - mem_size_t enum (MSIZE1/2/4/8).
  - mem_state_t {IDLE, BUS, DONE}.
  - is_load/is_store helper functions over instruction_type.
- One sub-module: mem_align. It is combinational and contains:
  - store lane shift and strobe generation;
  - load shift plus sign/zero extension.
  - It is instantiated once and reused for both directions.

Test Plan:
- SW to 0x1004, data 0xDEADBEEF_12345678; bus replies after 3 cycles:
  - dreq_size = 2, dreq_strobe = 0xF0, dreq_data = 0x12345678_00000000.
  - Fields are held all 3 cycles; out_wen = 0.
- LB from 0x2003, dresp_data = 0x0000_0000_8000_0000:
  - out_result = 0xFFFF_FFFF_FFFF_FF80, out_wen = 1.
- LBU, same stimulus as the LB case: out_result = 0x80.
- LWU, same stimulus as the LB case: with addr 0x2000, out_result = 0x8000_0000.
- ADD result 42 back-to-back with ADDI result 7, out_ready = 1:
  - out_valid on consecutive cycles with 42 then 7.
  - dreq_valid never asserts.
- LD issued, out_ready = 0 for 4 cycles after data_ok:
  - out_result is stable and in_ready = 0 until the handshake completes.
- Reset pulled low while in BUS:
  - dreq_valid drops immediately (asynchronous).
  - A stale dresp_data_ok after release produces no out_valid.
  - With MEM_MISALIGN_CHECK_EN defined, LH at 0x1001 gives out_misalign = 1 and out_result = 0x1001, with no bus request.
